// File: rtl/if_fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: bubble encoding,
// default reset PC and the fetch FSM state encodings.
package if_fetch_unit_pkg;

   localparam logic [31:0] INST_NOP         = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [1:0] ST_FETCH = 2'b00;
   localparam logic [1:0] ST_WAIT  = 2'b01;
   localparam logic [1:0] ST_HOLD  = 2'b10;

   typedef enum logic [1:0] {
      FETCH = ST_FETCH,
      WAIT  = ST_WAIT,
      HOLD  = ST_HOLD
   } fetch_state_t;

endpackage

// File: rtl/if_npc_sel.sv
// Next-PC selection for the fetch stage.
// Priority: redirect target > sequential PC+4 > hold current PC.
module if_npc_sel (
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        consume,
   input  logic [31:0] pc,
   output logic [31:0] next_pc
);

   // Redirect targets are word aligned by masking the two low bits
   always_comb begin
      next_pc = pc;
      if (redirect) begin
         next_pc = redirect_pc & ~32'h0000_0003;
      end else if (consume) begin
         next_pc = pc + 32'd4;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register. Keeps a single request
// outstanding on the req/gnt/rvalid memory port, buffers an instruction while
// decode is stalled and squashes fetches made stale by a PC redirect.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP      = INST_NOP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_if,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_pc_4,
   output logic [31:0] IF_inst,
   output logic        IF_valid
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  inst_buf;
   logic         kill;

   logic         data_ok;
   logic         offer;
   logic         consume;
   logic [31:0]  next_pc;

   // An instruction is on offer when live read data returns or the buffer is full
   always_comb begin
      data_ok = (state == WAIT) && imem_rvalid && !kill;
      offer   = data_ok || (state == HOLD);
      consume = offer && !stall_if;
   end

   // Outputs toward memory and IF/ID; a redirect or reset turns the offer into a bubble
   always_comb begin
      imem_req  = (state == FETCH) && !rst;
      imem_addr = pc;
      IF_pc_4   = rst ? (RESET_PC + 32'd4) : (pc + 32'd4);
      IF_valid  = offer && !redirect && !rst;
      IF_inst   = NOP;
      if (IF_valid) begin
         IF_inst = (state == HOLD) ? inst_buf : imem_rdata;
      end
   end

   if_npc_sel u_npc_sel (
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .consume     (consume),
      .pc          (pc),
      .next_pc     (next_pc)
   );

   // Fetch FSM: kill marks an in-flight response that belongs to a stale PC
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         state    <= FETCH;
         kill     <= 1'b0;
         inst_buf <= '0;
      end else begin
         pc <= next_pc;
         case (state)
            FETCH: begin
               if (imem_gnt) begin
                  state <= WAIT;
                  kill  <= redirect;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  kill <= 1'b0;
                  if (kill || redirect || !stall_if) begin
                     state <= FETCH;
                  end else begin
                     inst_buf <= imem_rdata;
                     state    <= HOLD;
                  end
               end else if (redirect) begin
                  kill <= 1'b1;
               end
            end
            HOLD: begin
               if (redirect || !stall_if) begin
                  state <= FETCH;
               end
            end
            default: begin
               state <= FETCH;
               kill  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: per-cycle vectors of memory/control
// inputs with the outputs expected before the next rising edge.
module tb_if_fetch_unit;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        chk_addr;
      logic        req;
      logic [31:0] addr;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] inst;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        stall_if;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] IF_pc_4;
   logic [31:0] IF_inst;
   logic        IF_valid;

   vec_t table_q[$];
   vec_t exp_q[$];
   int   num_checks = 0;
   int   num_errors = 0;
   int   step = 0;

   if_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .stall_if    (stall_if),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .IF_pc_4     (IF_pc_4),
      .IF_inst     (IF_inst),
      .IF_valid    (IF_valid)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic vec_t make_vec(
      input logic rst_i, input logic stall_i, input logic redir_i, input logic [31:0] rpc_i,
      input logic gnt_i, input logic rvalid_i, input logic [31:0] rdata_i,
      input logic chk_i, input logic req_i, input logic [31:0] addr_i,
      input logic [31:0] pc4_i, input logic valid_i, input logic [31:0] inst_i);
      vec_t v;
      v.rst = rst_i;   v.stall = stall_i; v.redir = redir_i; v.rpc = rpc_i;
      v.gnt = gnt_i;   v.rvalid = rvalid_i; v.rdata = rdata_i;
      v.chk_addr = chk_i; v.req = req_i; v.addr = addr_i;
      v.pc4 = pc4_i;   v.valid = valid_i; v.inst = inst_i;
      return v;
   endfunction

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      num_checks++;
      if (act !== exp) begin
         num_errors++;
         $display("[TB] FAIL step %0d %s: got %h, expected %h", step, name, act, exp);
      end
   endtask

   // Pop the oldest expectation and compare it against the live outputs
   task automatic check_output();
      vec_t e;
      if (exp_q.size() == 0) begin
         num_checks++;
         num_errors++;
         $display("[TB] FAIL step %0d scoreboard: got empty queue, expected an entry", step);
         return;
      end
      e = exp_q.pop_front();
      compare("imem_req", {31'd0, imem_req}, {31'd0, e.req});
      if (e.chk_addr) compare("imem_addr", imem_addr, e.addr);
      compare("IF_pc_4", IF_pc_4, e.pc4);
      compare("IF_valid", {31'd0, IF_valid}, {31'd0, e.valid});
      compare("IF_inst", IF_inst, e.inst);
   endtask

   // Drive one cycle of inputs after the falling edge, then sample outputs
   task automatic apply_stimulus(input vec_t v);
      @(negedge clk);
      rst         = v.rst;
      stall_if    = v.stall;
      redirect    = v.redir;
      redirect_pc = v.rpc;
      imem_gnt    = v.gnt;
      imem_rvalid = v.rvalid;
      imem_rdata  = v.rdata;
      exp_q.push_back(v);
      #1;
      check_output();
      step++;
   endtask

   initial begin
      rst = 1'b1; stall_if = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

      //                 rst stl rdr rpc           gnt rv  rdata         chk req addr          pc4           vld inst
      // reset
      table_q.push_back(make_vec(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        32'h4,        0, 32'h0));
      table_q.push_back(make_vec(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        32'h4,        0, 32'h0));
      // basic fetch, no stall
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h0,        32'h4,        0, 32'h0));
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        0, 1, 32'h2008_0001, 1, 0, 32'h0,       32'h4,        1, 32'h2008_0001));
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h4,        32'h8,        0, 32'h0));
      // fetch with 3-cycle stall through HOLD
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h4,        32'h8,        0, 32'h0));
      table_q.push_back(make_vec(0, 1, 0, 32'h0,        0, 1, 32'h2008_0001, 1, 0, 32'h4,       32'h8,        1, 32'h2008_0001));
      table_q.push_back(make_vec(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h4,        32'h8,        1, 32'h2008_0001));
      table_q.push_back(make_vec(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h4,        32'h8,        1, 32'h2008_0001));
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h4,        32'h8,        1, 32'h2008_0001));
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h8,        32'hC,        0, 32'h0));
      // redirect while waiting; rvalid two cycles later is dropped
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h8,        32'hC,        0, 32'h0));
      table_q.push_back(make_vec(0, 0, 1, 32'h103,      0, 0, 32'h0,        1, 0, 32'h8,        32'hC,        0, 32'h0));
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h100,      32'h104,      0, 32'h0));
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        0, 1, 32'hDEAD_BEEF, 1, 0, 32'h100,     32'h104,      0, 32'h0));
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h100,      32'h104,      0, 32'h0));
      // redirect together with gnt: next response is stale
      table_q.push_back(make_vec(0, 0, 1, 32'h200,      1, 0, 32'h0,        1, 1, 32'h100,      32'h104,      0, 32'h0));
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        0, 1, 32'h1111_1111, 1, 0, 32'h200,     32'h204,      0, 32'h0));
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h200,      32'h204,      0, 32'h0));
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        0, 1, 32'h2222_2222, 1, 0, 32'h200,     32'h204,      1, 32'h2222_2222));
      // redirect in FETCH without gnt: address changes next cycle
      table_q.push_back(make_vec(0, 0, 1, 32'h300,      0, 0, 32'h0,        1, 1, 32'h204,      32'h208,      0, 32'h0));
      // redirect plus stall in HOLD
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h300,      32'h304,      0, 32'h0));
      table_q.push_back(make_vec(0, 1, 0, 32'h0,        0, 1, 32'h3333_3333, 1, 0, 32'h300,     32'h304,      1, 32'h3333_3333));
      table_q.push_back(make_vec(0, 1, 1, 32'h400,      0, 0, 32'h0,        1, 0, 32'h300,      32'h304,      0, 32'h0));
      table_q.push_back(make_vec(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h400,      32'h404,      0, 32'h0));
      // stray rvalid in FETCH is ignored
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        0, 1, 32'h4444_4444, 1, 1, 32'h400,     32'h404,      0, 32'h0));
      // second redirect while kill is already set
      table_q.push_back(make_vec(0, 0, 1, 32'h500,      1, 0, 32'h0,        1, 1, 32'h400,      32'h404,      0, 32'h0));
      table_q.push_back(make_vec(0, 0, 1, 32'h604,      0, 0, 32'h0,        1, 0, 32'h500,      32'h504,      0, 32'h0));
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        0, 1, 32'h5555_5555, 1, 0, 32'h604,     32'h608,      0, 32'h0));
      table_q.push_back(make_vec(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h604,      32'h608,      0, 32'h0));

      foreach (table_q[i]) apply_stimulus(table_q[i]);

      // PC wraparound at the top of the address space
      apply_stimulus(make_vec(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0,         1, 1, 32'h604,       32'h608, 0, 32'h0));
      apply_stimulus(make_vec(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'h0,   0, 32'h0));
      apply_stimulus(make_vec(0, 0, 0, 32'h0,         0, 1, 32'h6666_6666, 1, 0, 32'hFFFF_FFFC, 32'h0,   1, 32'h6666_6666));
      // move away from address 0, then reset mid-transaction in WAIT
      apply_stimulus(make_vec(0, 0, 1, 32'h80,        0, 0, 32'h0,         1, 1, 32'h0,         32'h4,   0, 32'h0));
      apply_stimulus(make_vec(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 32'h80,        32'h84,  0, 32'h0));
      apply_stimulus(make_vec(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h80,        32'h4,   0, 32'h0));
      apply_stimulus(make_vec(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h0,         32'h4,   0, 32'h0));

      if (exp_q.size() != 0) begin
         num_checks++;
         num_errors++;
         $display("[TB] FAIL scoreboard drain: got %0d entries left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
